// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity (UART_TX_PARITY_EN), STOP_BITS stop bits.
// Latency: line goes low one cycle after the sampled sendBtn rising edge; each bit lasts CLK_DIV cycles.
// Backpressure: none; rising edges while busy are dropped, a launch may coincide with the last stop edge.
module uart_tx_frame #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 100,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sendBtn,
  input  logic [DATA_W-1:0] data,
  output logic              bsOut,
  output logic              sendSig,
  output logic              frameDone
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (DATA_W < 1 || DATA_W > 32) begin : gBadDataW
    $error("uart_tx_frame: DATA_W must be 1..32");
  end
  if (CLK_DIV < 2) begin : gBadClkDiv
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : gBadParity
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } stateT;

  stateT             state, stateN;
  logic              sendQ;
  logic [BAUD_W-1:0] baudCnt, baudN;
  logic [BIT_W-1:0]  bitCnt, bitN;
  logic [DATA_W-1:0] shiftReg, shiftN;
  logic              bsOutN, sendSigN, frameDoneN;
  logic              launch, tick, capture;
`ifdef UART_TX_PARITY_EN
  logic              parBit, parBitN;
`endif

  assign launch = sendBtn && !sendQ;
  assign tick   = (baudCnt == LAST_BAUD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sendQ     <= 1'b0;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      bsOut     <= 1'b1;
      sendSig   <= 1'b0;
      frameDone <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parBit    <= 1'b0;
`endif
    end else begin
      state     <= stateN;
      sendQ     <= sendBtn;
      baudCnt   <= baudN;
      bitCnt    <= bitN;
      shiftReg  <= shiftN;
      bsOut     <= bsOutN;
      sendSig   <= sendSigN;
      frameDone <= frameDoneN;
`ifdef UART_TX_PARITY_EN
      parBit    <= parBitN;
`endif
    end
  end

  always_comb begin
    stateN     = state;
    baudN      = baudCnt;
    bitN       = bitCnt;
    shiftN     = shiftReg;
    frameDoneN = 1'b0;
    capture    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parBitN    = parBit;
`endif

    case (state)
      IDLE: begin
        if (launch) begin
          capture = 1'b1;
          stateN  = START;
          baudN   = '0;
          bitN    = '0;
        end
      end
      START: begin
        if (tick) begin
          baudN  = '0;
          bitN   = '0;
          stateN = DATA;
        end else begin
          baudN = baudCnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          baudN  = '0;
          shiftN = shiftReg >> 1;
          if (bitCnt == LAST_DATA) begin
            bitN   = '0;
`ifdef UART_TX_PARITY_EN
            stateN = PARITY;
`else
            stateN = STOP;
`endif
          end else begin
            bitN = bitCnt + BIT_W'(1);
          end
        end else begin
          baudN = baudCnt + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          baudN  = '0;
          bitN   = '0;
          stateN = STOP;
        end else begin
          baudN = baudCnt + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          baudN = '0;
          if (bitCnt == LAST_STOP) begin
            // A launch on the final stop edge chains straight into the next start bit.
            frameDoneN = 1'b1;
            bitN       = '0;
            if (launch) begin
              capture = 1'b1;
              stateN  = START;
            end else begin
              stateN = IDLE;
            end
          end else begin
            bitN = bitCnt + BIT_W'(1);
          end
        end else begin
          baudN = baudCnt + BAUD_W'(1);
        end
      end
      default: stateN = IDLE;
    endcase

    if (capture) begin
      shiftN  = data;
`ifdef UART_TX_PARITY_EN
      parBitN = (^data) ^ (PARITY_ODD != 0);
`endif
    end

    case (stateN)
      START:   bsOutN = 1'b0;
      DATA:    bsOutN = shiftN[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  bsOutN = parBitN;
`endif
      default: bsOutN = 1'b1;
    endcase
    sendSigN = (stateN != IDLE);
  end

endmodule
